// File: rtl/hdmi_i2c_write_master.sv
// Single-shot I2C write master: START, device address (W), register, value, STOP.
// Each protocol phase is four quarter-periods of CLK_DIV clk_in cycles.
module hdmi_i2c_write_master #(
  parameter int CLK_DIV = 125
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  dev_addr,
  input  logic [15:0] reg_data,
  output logic        ready_out,
  output logic        ack,
  output logic [7:0]  states,
  inout  wire         i2c_sda,
  output logic        i2c_scl
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    START    = 4'd1,
    ADDR     = 4'd2,
    ADDR_ACK = 4'd3,
    REG      = 4'd4,
    REG_ACK  = 4'd5,
    DATA     = 4'd6,
    DATA_ACK = 4'd7,
    STOP     = 4'd8,
    DONE     = 4'd9
  } state_t;

  localparam logic [9:0] QMAX = 10'(CLK_DIV - 1);

  state_t      state, state_next;
  logic [9:0]  qcnt;
  logic [1:0]  quarter;
  logic [2:0]  bidx;
  logic [7:0]  shift;
  logic [7:0]  reg_byte;
  logic [7:0]  data_byte;
  logic        armed;
  logic [1:0]  sda_sync;
  logic        sda_low;
  logic        quarter_end;
  logic        phase_end;
  logic        nack_seen;

  assign quarter_end = (qcnt == QMAX);
  assign phase_end   = quarter_end && (quarter == 2'd3);
  assign nack_seen   = sda_sync[1];
  assign states      = {1'b0, bidx, state};
  assign i2c_sda     = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= IDLE;
      qcnt      <= '0;
      quarter   <= '0;
      bidx      <= '0;
      shift     <= '0;
      reg_byte  <= '0;
      data_byte <= '0;
      armed     <= 1'b0;
      ack       <= 1'b0;
      ready_out <= 1'b1;
      sda_sync  <= 2'b11;
    end else begin
      state     <= state_next;
      ready_out <= (state == IDLE);
      sda_sync  <= {sda_sync[0], i2c_sda};

      if (state == IDLE || state == DONE) begin
        qcnt    <= '0;
        quarter <= '0;
      end else if (quarter_end) begin
        qcnt    <= '0;
        quarter <= quarter + 2'd1;
      end else begin
        qcnt <= qcnt + 10'd1;
      end

      // A held start must drop for one idle cycle before it can launch again.
      if (state == IDLE) begin
        if (start && armed) begin
          shift     <= {dev_addr[7:1], 1'b0};
          reg_byte  <= reg_data[15:8];
          data_byte <= reg_data[7:0];
          armed     <= 1'b0;
          ack       <= 1'b0;
        end else if (!start) begin
          armed <= 1'b1;
        end
      end

      if (state == DONE) bidx <= '0;

      if (phase_end) begin
        case (state)
          START: bidx <= 3'd7;
          ADDR, REG, DATA: begin
            bidx  <= bidx - 3'd1;
            shift <= {shift[6:0], 1'b0};
          end
          ADDR_ACK: if (!nack_seen) shift <= reg_byte; else ack <= 1'b0;
          REG_ACK:  if (!nack_seen) shift <= data_byte; else ack <= 1'b0;
          DATA_ACK: ack <= !nack_seen;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start && armed) state_next = START;
      START:    if (phase_end) state_next = ADDR;
      ADDR:     if (phase_end && bidx == 3'd0) state_next = ADDR_ACK;
      ADDR_ACK: if (phase_end) state_next = nack_seen ? STOP : REG;
      REG:      if (phase_end && bidx == 3'd0) state_next = REG_ACK;
      REG_ACK:  if (phase_end) state_next = nack_seen ? STOP : DATA;
      DATA:     if (phase_end && bidx == 3'd0) state_next = DATA_ACK;
      DATA_ACK: if (phase_end) state_next = STOP;
      STOP:     if (phase_end) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // SCL/SDA decode from the registered phase; data bits change only while SCL is low.
  always_comb begin
    i2c_scl = 1'b1;
    sda_low = 1'b0;
    case (state)
      START: sda_low = quarter[1];
      ADDR, REG, DATA: begin
        i2c_scl = quarter[1];
        sda_low = ~shift[7];
      end
      ADDR_ACK, REG_ACK, DATA_ACK: i2c_scl = quarter[1];
      STOP: begin
        i2c_scl = (quarter != 2'd0);
        sda_low = ~quarter[1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hdmi_i2c_write_master.sv
// Bench for hdmi_i2c_write_master: bus-level slave model, byte and completion scoreboards.
module tb_hdmi_i2c_write_master;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  dev_addr;
  logic [15:0] reg_data;
  logic        ready_out;
  logic        ack;
  logic [7:0]  states;
  logic        scl;
  wire         sda_bus;
  logic        slave_low = 1'b0;

  pullup (sda_bus);
  assign sda_bus = slave_low ? 1'b0 : 1'bz;

  hdmi_i2c_write_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk_in    (clk),
    .reset     (reset),
    .start     (start),
    .dev_addr  (dev_addr),
    .reg_data  (reg_data),
    .ready_out (ready_out),
    .ack       (ack),
    .states    (states),
    .i2c_sda   (sda_bus),
    .i2c_scl   (scl)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int nchk = 0;
  int nerr = 0;
  int exp_starts = 0;
  int exp_stops = 0;
  int got_starts = 0;
  int got_stops = 0;
  int nack_idx = 3;

  logic [7:0]  exp_q[$];
  logic [15:0] exp_done_q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // slave model: detects START/STOP, captures bytes, ACKs unless told to NACK a byte
  logic       prev_c = 1'b1, prev_s = 1'b1, cur_c, cur_s;
  logic       active = 1'b0;
  logic [7:0] sh = '0;
  int         bitcnt = 0;
  int         byte_idx = 0;

  always @(negedge clk) begin
    cur_c = scl;
    cur_s = sda_bus;
    if (prev_c && cur_c && prev_s && !cur_s) begin
      got_starts++;
      active = 1'b1;
      bitcnt = 0;
      byte_idx = 0;
    end else if (prev_c && cur_c && !prev_s && cur_s) begin
      got_stops++;
      active = 1'b0;
      slave_low = 1'b0;
    end else if (active && !prev_c && cur_c) begin
      if (bitcnt < 8) begin
        sh = {sh[6:0], cur_s};
        bitcnt++;
        if (bitcnt == 8) begin
          if (exp_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL bus_byte: got %0h expected none", sh);
          end else begin
            chk("bus_byte", 32'(sh), 32'(exp_q.pop_front()));
          end
        end
      end else begin
        bitcnt = 0;
        byte_idx++;
      end
    end else if (active && prev_c && !cur_c) begin
      slave_low = (bitcnt == 8) && (byte_idx != nack_idx);
    end
    prev_c = cur_c;
    prev_s = cur_s;
  end

  // completion monitor: cycles from accept edge to ready_out rising, plus ack
  logic prev_ready = 1'b1;
  logic in_txn = 1'b0;
  int   lat_cnt = 0;
  logic [15:0] e_done;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      in_txn = 1'b0;
    end else begin
      if (in_txn) lat_cnt++;
      if (prev_ready && !ready_out) begin
        in_txn = 1'b1;
        lat_cnt = 1;
      end else if (in_txn && ready_out) begin
        in_txn = 1'b0;
        if (exp_done_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL done: got completion latency %0d expected none", lat_cnt);
        end else begin
          e_done = exp_done_q.pop_front();
          chk("latency", 32'(lat_cnt), 32'(e_done[14:0]));
          chk("ack", 32'(ack), 32'(e_done[15]));
        end
      end
    end
    prev_ready = ready_out;
  end

  // driver
  task automatic wait_ready();
    int budget = 0;
    while (!ready_out && budget < 100) begin
      @(negedge clk);
      budget++;
    end
  endtask

  task automatic txn(input logic [7:0] da, input logic [15:0] rd,
                     input logic [7:0] ea, input logic [7:0] er, input logic [7:0] ed,
                     input int nk, input int lat, input logic eack,
                     input bit scramble, input bit hold);
    int budget = 0;
    wait_ready();
    @(negedge clk);
    start = 1'b0;
    nack_idx = nk;
    @(negedge clk);
    exp_q.push_back(ea);
    if (nk >= 1) exp_q.push_back(er);
    if (nk >= 2) exp_q.push_back(ed);
    exp_done_q.push_back({eack, 15'(lat)});
    exp_starts++;
    exp_stops++;
    dev_addr = da;
    reg_data = rd;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    while (exp_done_q.size() != 0 && budget < 3000) begin
      @(negedge clk);
      if (scramble) begin
        dev_addr = 8'($urandom_range(0, 255));
        reg_data = 16'($urandom_range(0, 65535));
      end
      budget++;
    end
    if (exp_done_q.size() != 0) begin
      nchk++;
      nerr++;
      $display("FAIL txn_timeout: got no completion expected one within 3000 cycles");
      exp_done_q.delete();
    end
  endtask

  initial begin
    int budget;
    reset = 1'b1;
    start = 1'b0;
    dev_addr = '0;
    reg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready_out), 1);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_states", 32'(states), 0);
    chk("rst_scl", 32'(scl), 1);
    chk("rst_sda", 32'(sda_bus), 1);
    @(negedge clk);
    reset = 1'b0;

    // full ACK, address NACK, register NACK, data NACK
    txn(8'h72, 16'h9803, 8'h72, 8'h98, 8'h03, 3, 466, 1'b1, 1'b0, 1'b0);
    txn(8'h72, 16'h1122, 8'h72, 8'h11, 8'h22, 0, 178, 1'b0, 1'b0, 1'b0);
    txn(8'h3B, 16'h4455, 8'h3A, 8'h44, 8'h55, 1, 322, 1'b0, 1'b0, 1'b0);
    txn(8'h72, 16'h9803, 8'h72, 8'h98, 8'h03, 2, 466, 1'b0, 1'b0, 1'b0);
    // inputs scrambled every cycle after accept; bit 0 of address forced low
    txn(8'hA5, 16'h5A3C, 8'hA4, 8'h5A, 8'h3C, 3, 466, 1'b1, 1'b1, 1'b0);

    // start held high for 1000 cycles: one transaction only
    txn(8'h72, 16'h1234, 8'h72, 8'h12, 8'h34, 3, 466, 1'b1, 1'b0, 1'b1);
    repeat (540) @(negedge clk);
    chk("hold_ready", 32'(ready_out), 1);
    chk("hold_states", 32'(states), 0);
    txn(8'h10, 16'hABCD, 8'h10, 8'hAB, 8'hCD, 3, 466, 1'b1, 1'b0, 1'b0);

    // reset during register bit 4
    wait_ready();
    @(negedge clk);
    start = 1'b0;
    nack_idx = 3;
    @(negedge clk);
    exp_q.push_back(8'h72);
    exp_starts++;
    dev_addr = 8'h72;
    reg_data = 16'h5511;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    budget = 0;
    while (!(states == 8'h44 && scl == 1'b0) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    chk("reach_reg_bit4", 32'(budget < 2000), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_scl", 32'(scl), 1);
    chk("midrst_sda", 32'(sda_bus), 1);
    chk("midrst_ready", 32'(ready_out), 1);
    chk("midrst_ack", 32'(ack), 0);
    chk("midrst_states", 32'(states), 0);
    @(negedge clk);
    reset = 1'b0;
    txn(8'h72, 16'h0001, 8'h72, 8'h00, 8'h01, 3, 466, 1'b1, 1'b0, 1'b0);

    repeat (10) @(negedge clk);
    chk("bytes_left", 32'(exp_q.size()), 0);
    chk("done_left", 32'(exp_done_q.size()), 0);
    chk("start_count", 32'(got_starts), 32'(exp_starts));
    chk("stop_count", 32'(got_stops), 32'(exp_stops));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
